// File: rtl/rdi_multi_timer_if.sv
// ============================================================================
// Module      : rdi_multi_timer_if
// Description : Control/status bundle between the RDI FSM and the timer.
//               Optional hold lane is present when RDI_TIMER_HOLD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rdi_multi_timer_if #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 4
);
    logic [PRESC_W-1:0]      i_clk_div_ratio;
    logic [NUM_CH-1:0]       i_start;
    logic [NUM_CH-1:0]       i_stop;
    logic [NUM_CH-1:0]       i_mode;
    logic [NUM_CH*CNT_W-1:0] i_terminal_cnt;
`ifdef RDI_TIMER_HOLD_EN
    logic [NUM_CH-1:0]       i_hold;
`endif
    logic [NUM_CH-1:0]       o_busy;
    logic [NUM_CH-1:0]       o_done;
    logic [NUM_CH-1:0]       o_done_pulse;
    logic [NUM_CH*CNT_W-1:0] o_count;

    modport master (
`ifdef RDI_TIMER_HOLD_EN
        output i_hold,
`endif
        output i_clk_div_ratio, i_start, i_stop, i_mode, i_terminal_cnt,
        input  o_busy, o_done, o_done_pulse, o_count
    );

    modport slave (
`ifdef RDI_TIMER_HOLD_EN
        input  i_hold,
`endif
        input  i_clk_div_ratio, i_start, i_stop, i_mode, i_terminal_cnt,
        output o_busy, o_done, o_done_pulse, o_count
    );
endinterface

`default_nettype wire

// File: rtl/rdi_multi_timer.sv
// ============================================================================
// Module      : rdi_multi_timer
// Description : Multi-channel prescaled one-shot/periodic timer on the sideband
//               clock. Define RDI_TIMER_HOLD_EN to add per-channel hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rdi_multi_timer #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 4
) (
    input  wire                  i_clk_sb,
    input  wire                  i_rst_n,
    rdi_multi_timer_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [NUM_CH-1:0]       w_busy;
    logic [NUM_CH-1:0]       w_done;
    logic [NUM_CH-1:0]       w_pulse;
    logic [NUM_CH*CNT_W-1:0] w_count;

    assign bus.o_busy       = w_busy;
    assign bus.o_done       = w_done;
    assign bus.o_done_pulse = w_pulse;
    assign bus.o_count      = w_count;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        state_t             state_q, state_d;
        logic [PRESC_W-1:0] presc_q, presc_d;
        logic [PRESC_W-1:0] ratio_q, ratio_d;
        logic [CNT_W-1:0]   count_q, count_d;
        logic [CNT_W-1:0]   term_q,  term_d;
        logic               mode_q,  mode_d;
        logic               pulse_q, pulse_d;
        logic               w_hold;
        logic [CNT_W-1:0]   w_term_in;
        logic [CNT_W-1:0]   w_count_inc;

`ifdef RDI_TIMER_HOLD_EN
        assign w_hold = bus.i_hold[n];
`else
        assign w_hold = 1'b0;
`endif
        assign w_term_in   = bus.i_terminal_cnt[n*CNT_W +: CNT_W];
        assign w_count_inc = count_q + CNT_W'(1);

        always_ff @(posedge i_clk_sb or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state_q <= ST_IDLE;
                presc_q <= '0;
                ratio_q <= '0;
                count_q <= '0;
                term_q  <= '0;
                mode_q  <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                presc_q <= presc_d;
                ratio_q <= ratio_d;
                count_q <= count_d;
                term_q  <= term_d;
                mode_q  <= mode_d;
                pulse_q <= pulse_d;
            end
        end

        // Stop outranks start, and both pre-empt any expiry in the same cycle.
        always_comb begin
            state_d = state_q;
            presc_d = presc_q;
            ratio_d = ratio_q;
            count_d = count_q;
            term_d  = term_q;
            mode_d  = mode_q;
            pulse_d = 1'b0;
            if (bus.i_stop[n]) begin
                state_d = ST_IDLE;
                presc_d = '0;
                count_d = '0;
            end else if (bus.i_start[n]) begin
                state_d = ST_RUN;
                presc_d = '0;
                count_d = '0;
                ratio_d = bus.i_clk_div_ratio;
                mode_d  = bus.i_mode[n];
                term_d  = (w_term_in == '0) ? CNT_W'(1) : w_term_in;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (!w_hold) begin
                            if (presc_q == ratio_q) begin
                                presc_d = '0;
                                if (w_count_inc == term_q) begin
                                    pulse_d = 1'b1;
                                    if (mode_q) begin
                                        count_d = '0;
                                    end else begin
                                        count_d = term_q;
                                        state_d = ST_DONE;
                                    end
                                end else begin
                                    count_d = w_count_inc;
                                end
                            end else begin
                                presc_d = presc_q + PRESC_W'(1);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        assign w_busy[n]                  = (state_q == ST_RUN);
        assign w_done[n]                  = (state_q == ST_DONE);
        assign w_pulse[n]                 = pulse_q;
        assign w_count[n*CNT_W +: CNT_W]  = count_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_rdi_multi_timer.sv
// ============================================================================
// Module      : tb_rdi_multi_timer
// Description : Scoreboard bench for rdi_multi_timer; expiry pulses are checked
//               against a queue of hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rdi_multi_timer;
    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 16;
    localparam int PRESC_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rdi_multi_timer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) bus ();

    rdi_multi_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
        .i_clk_sb (clk),
        .i_rst_n  (rst_n),
        .bus      (bus)
    );

    typedef struct {
        int ch;
        int cyc;
        int cnt;
        bit done;
        bit busy;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_n   = 0;
    bit   mon_en   = 1'b0;

    always @(posedge clk) edge_n = edge_n + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s @edge %0d: got %0d expected %0d", nm, edge_n, act, exp);
        end
    endtask

    function automatic int cnt_of(input int ch);
        return int'(bus.o_count[ch*CNT_W +: CNT_W]);
    endfunction

    // Monitor: every expiry pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (bus.o_done_pulse[ch] === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        checks   = checks + 1;
                        failures = failures + 1;
                        $display("FAIL unexpected_pulse ch%0d @edge %0d: got pulse expected none", ch, edge_n);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("pulse_ch",   64'(ch),                 64'(e.ch));
                        chk("pulse_edge", 64'(edge_n),             64'(e.cyc));
                        chk("pulse_count", 64'(cnt_of(ch)),        64'(e.cnt));
                        chk("pulse_done", 64'(bus.o_done[ch]),     64'(e.done));
                        chk("pulse_busy", 64'(bus.o_busy[ch]),     64'(e.busy));
                    end
                end
            end
            while (sb_q.size() > 0 && sb_q[0].cyc < edge_n) begin
                checks   = checks + 1;
                failures = failures + 1;
                $display("FAIL missed_pulse ch%0d: got no pulse expected one @edge %0d", sb_q[0].ch, sb_q[0].cyc);
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic wait_edge(input int target);
        while (edge_n < target) @(negedge clk);
    endtask

    // Issued at a negedge; start is sampled at edge k. Mid-run inputs are then scrambled.
    task automatic start_ch(input int ch, input bit mode, input int r, input int t,
                            input int npulse, output int k);
        int teff;
        bus.i_start[ch]                       = 1'b1;
        bus.i_mode[ch]                        = mode;
        bus.i_clk_div_ratio                   = r[PRESC_W-1:0];
        bus.i_terminal_cnt[ch*CNT_W +: CNT_W] = t[CNT_W-1:0];
        k    = edge_n + 1;
        teff = (t == 0) ? 1 : t;
        for (int i = 1; i <= npulse; i++) begin
            exp_t e;
            e.ch   = ch;
            e.cyc  = k + i * teff * (r + 1);
            e.cnt  = mode ? 0 : teff;
            e.done = !mode;
            e.busy = mode;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.i_start[ch]                       = 1'b0;
        bus.i_mode[ch]                        = ~mode;
        bus.i_clk_div_ratio                   = '1;
        bus.i_terminal_cnt[ch*CNT_W +: CNT_W] = '1;
    endtask

    task automatic stop_ch(input int ch);
        bus.i_stop[ch] = 1'b1;
        @(negedge clk);
        bus.i_stop[ch] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, k2;
        bus.i_clk_div_ratio = '0;
        bus.i_start         = '0;
        bus.i_stop          = '0;
        bus.i_mode          = '0;
        bus.i_terminal_cnt  = '0;
`ifdef RDI_TIMER_HOLD_EN
        bus.i_hold          = '0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_busy",  64'(bus.o_busy),       64'(0));
        chk("reset_done",  64'(bus.o_done),       64'(0));
        chk("reset_pulse", 64'(bus.o_done_pulse), 64'(0));
        chk("reset_count", 64'(bus.o_count),      64'(0));
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // One-shot, R=7, T=4: expiry at k+32, then DONE held.
        start_ch(0, 1'b0, 7, 4, 1, k);
        chk("t1_busy_at_start", 64'(bus.o_busy[0]), 64'(1));
        wait_edge(k + 33);
        chk("t1_done_held",  64'(bus.o_done[0]),       64'(1));
        chk("t1_busy_low",   64'(bus.o_busy[0]),       64'(0));
        chk("t1_count_held", 64'(cnt_of(0)),           64'(4));
        chk("t1_pulse_gone", 64'(bus.o_done_pulse[0]), 64'(0));
        stop_ch(0);
        chk("t1_stop_done", 64'(bus.o_done[0]), 64'(0));

        // Periodic, R=0, T=3: pulses at k+3,k+6,k+9; count 1,2,0.
        start_ch(1, 1'b1, 0, 3, 3, k);
        wait_edge(k + 1);
        chk("t2_count1", 64'(cnt_of(1)), 64'(1));
        wait_edge(k + 2);
        chk("t2_count2", 64'(cnt_of(1)), 64'(2));
        wait_edge(k + 3);
        chk("t2_count0", 64'(cnt_of(1)),     64'(0));
        chk("t2_done0",  64'(bus.o_done[1]), 64'(0));
        wait_edge(k + 10);
        stop_ch(1);
        chk("t2_stopped", 64'(bus.o_busy[1]), 64'(0));
        wait_edge(k + 16);

        // Restart mid-run: old expiry at k+5 must not appear.
        start_ch(0, 1'b0, 0, 5, 0, k);
        wait_edge(k + 2);
        chk("t3_count2", 64'(cnt_of(0)), 64'(2));
        start_ch(0, 1'b0, 1, 2, 1, k2);
        chk("t3_restart_count", 64'(cnt_of(0)), 64'(0));
        wait_edge(k2 + 6);
        chk("t3_done",  64'(bus.o_done[0]), 64'(1));
        chk("t3_count", 64'(cnt_of(0)),     64'(2));
        stop_ch(0);

        // Simultaneous start+stop on a running channel: stop wins.
        start_ch(1, 1'b0, 0, 10, 0, k);
        wait_edge(k + 3);
        bus.i_start[1] = 1'b1;
        bus.i_stop[1]  = 1'b1;
        @(negedge clk);
        bus.i_start[1] = 1'b0;
        bus.i_stop[1]  = 1'b0;
        chk("t4a_busy",  64'(bus.o_busy[1]), 64'(0));
        chk("t4a_done",  64'(bus.o_done[1]), 64'(0));
        chk("t4a_count", 64'(cnt_of(1)),     64'(0));
        wait_edge(k + 15);

        // Stop sampled on the expiry edge suppresses the pulse.
        start_ch(1, 1'b0, 0, 3, 0, k);
        wait_edge(k + 2);
        stop_ch(1);
        chk("t4b_busy",  64'(bus.o_busy[1]),       64'(0));
        chk("t4b_done",  64'(bus.o_done[1]),       64'(0));
        chk("t4b_count", 64'(cnt_of(1)),           64'(0));
        chk("t4b_pulse", 64'(bus.o_done_pulse[1]), 64'(0));
        wait_edge(k + 8);

        // T=0 behaves as T=1.
        start_ch(0, 1'b0, 0, 0, 1, k);
        wait_edge(k + 2);
        chk("t5_done", 64'(bus.o_done[0]), 64'(1));
        stop_ch(0);

        // Async reset mid-run clears outputs before the next clock edge.
        start_ch(1, 1'b1, 0, 100, 0, k);
        wait_edge(k + 5);
        chk("t5_pre_reset_busy", 64'(bus.o_busy[1]), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy",  64'(bus.o_busy),       64'(0));
        chk("t5_rst_done",  64'(bus.o_done),       64'(0));
        chk("t5_rst_pulse", 64'(bus.o_done_pulse), 64'(0));
        chk("t5_rst_count", 64'(bus.o_count),      64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef RDI_TIMER_HOLD_EN
        // Hold sampled on edges k+2..k+11 delays expiry to k+16.
        start_ch(0, 1'b0, 0, 6, 1, k);
        wait_edge(k + 1);
        bus.i_hold[0] = 1'b1;
        wait_edge(k + 11);
        chk("t6_frozen_count", 64'(cnt_of(0)), 64'(1));
        bus.i_hold[0] = 1'b0;
        wait_edge(k + 18);
        chk("t6_done", 64'(bus.o_done[0]), 64'(1));
        stop_ch(0);
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
